rf_tx_iq_streamer: RTL and testbench

RF_TX_IQ_STREAMER -- requirements
Module: rf_tx_iq_streamer

---
 rtl/rf_tx_iq_streamer.sv | 165 ++++++++++++++++
 tb/tb_rf_tx_iq_streamer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_tx_iq_streamer.sv
`default_nettype none
// ============================================================================
// Module   : rf_tx_iq_streamer
// Purpose  : Buffers IQ pairs and serialises them to a DAC as I then Q, with
//            one-shot or cyclic replay. Optional macro RFTX_OFFSET_BINARY_EN
//            selects offset-binary DAC coding.
// Revision : 1.0 - initial release
// ============================================================================
module rf_tx_iq_streamer #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 6
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [2*DATA_W-1:0]   s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  en_in,
  input  logic                  loop_mode,
  output logic [DATA_W-1:0]     rftxdata,
  output logic                  rftxen,
  output logic                  rftxiqsel,
  output logic                  underrun,
  output logic [ADDR_W:0]       level
);

  localparam int              c_depth = 1 << ADDR_W;
  localparam logic [ADDR_W:0] c_full  = {1'b1, {ADDR_W{1'b0}}};
`ifdef RFTX_OFFSET_BINARY_EN
  localparam logic [DATA_W-1:0] c_idle_code = {1'b1, {(DATA_W-1){1'b0}}};
`else
  localparam logic [DATA_W-1:0] c_idle_code = '0;
`endif

  function automatic logic [DATA_W-1:0] fmt_sample(input logic [DATA_W-1:0] s);
`ifdef RFTX_OFFSET_BINARY_EN
    return {~s[DATA_W-1], s[DATA_W-2:0]};
`else
    return s;
`endif
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    I_PH = 2'd1,
    Q_PH = 2'd2
  } state_t;

  state_t              r_state, w_next;
  logic                r_loop, w_next_loop;
  logic                r_rdy_en;
  logic [ADDR_W-1:0]   r_wr_ptr, r_rd_ptr, r_ofs;
  logic [ADDR_W-1:0]   w_next_ofs, w_ofs_adv, w_rd_addr, w_out_addr;
  logic [ADDR_W:0]     r_level;
  logic                w_wr, w_pop, w_avail, w_set_ur;
  logic [2*DATA_W-1:0] w_cur_pair, w_nxt_pair;
  logic [2*DATA_W-1:0] r_mem [c_depth];

  // Writes are blocked while replaying so the loop window stays fixed.
  assign s_ready  = r_rdy_en && (r_level != c_full) && !((r_state != IDLE) && r_loop);
  assign w_wr     = s_valid && s_ready;
  assign level    = r_level;

  assign w_rd_addr  = r_rd_ptr + r_ofs;
  assign w_ofs_adv  = (({1'b0, r_ofs} + (ADDR_W+1)'(1)) == r_level) ? '0 : r_ofs + ADDR_W'(1);
  assign w_cur_pair = r_mem[w_rd_addr];
  assign w_nxt_pair = r_mem[w_out_addr];

  always_comb begin
    w_next      = r_state;
    w_next_loop = r_loop;
    w_next_ofs  = r_ofs;
    w_out_addr  = w_rd_addr;
    w_pop       = 1'b0;
    w_avail     = 1'b0;
    w_set_ur    = 1'b0;
    case (r_state)
      IDLE: begin
        if (en_in && (r_level != '0)) begin
          w_next      = I_PH;
          w_next_loop = loop_mode;
          w_next_ofs  = '0;
        end
      end
      I_PH: w_next = Q_PH;
      Q_PH: begin
        // Availability ignores a same-cycle write: there is no write-to-read bypass.
        if (r_loop) begin
          w_next_ofs = w_ofs_adv;
          w_out_addr = r_rd_ptr + w_ofs_adv;
          w_avail    = 1'b1;
        end else begin
          w_pop      = 1'b1;
          w_out_addr = r_rd_ptr + ADDR_W'(1);
          w_avail    = (r_level > (ADDR_W+1)'(1));
        end
        if (!en_in) begin
          w_next     = IDLE;
          w_next_ofs = '0;
        end else if (w_avail) begin
          w_next = I_PH;
        end else begin
          w_next     = IDLE;
          w_next_ofs = '0;
          w_set_ur   = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= s_data;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state   <= IDLE;
      r_loop    <= 1'b0;
      r_ofs     <= '0;
      r_rdy_en  <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      underrun  <= 1'b0;
      rftxdata  <= c_idle_code;
      rftxen    <= 1'b0;
      rftxiqsel <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_loop   <= w_next_loop;
      r_ofs    <= w_next_ofs;
      r_rdy_en <= 1'b1;
      if (w_wr)  r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + (ADDR_W+1)'(1);
        2'b01:   r_level <= r_level - (ADDR_W+1)'(1);
        default: r_level <= r_level;
      endcase
      if (w_set_ur)                        underrun <= 1'b1;
      else if ((r_state == IDLE) && !en_in) underrun <= 1'b0;
      // Outputs are registered from the next state so rftxen rises on the entry edge.
      case (w_next)
        I_PH: begin
          rftxdata  <= fmt_sample(w_nxt_pair[2*DATA_W-1:DATA_W]);
          rftxen    <= 1'b1;
          rftxiqsel <= 1'b1;
        end
        Q_PH: begin
          rftxdata  <= fmt_sample(w_cur_pair[DATA_W-1:0]);
          rftxen    <= 1'b1;
          rftxiqsel <= 1'b0;
        end
        default: begin
          rftxdata  <= c_idle_code;
          rftxen    <= 1'b0;
          rftxiqsel <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_tx_iq_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_tx_iq_streamer
// Purpose  : Directed bench: streaming table, loop replay, mid-pair disable,
//            full buffer and asynchronous reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_tx_iq_streamer;

  localparam int DW = 12;
  localparam int AW = 6;

`ifdef RFTX_OFFSET_BINARY_EN
  localparam logic [DW-1:0] c_idle = 12'h800;
`else
  localparam logic [DW-1:0] c_idle = 12'h000;
`endif

  logic            clk_clk = 1'b0;
  logic            reset_reset_n;
  logic [2*DW-1:0] s_data;
  logic            s_valid;
  logic            s_ready;
  logic            en_in;
  logic            loop_mode;
  logic [DW-1:0]   rftxdata;
  logic            rftxen;
  logic            rftxiqsel;
  logic            underrun;
  logic [AW:0]     level;

  int checks   = 0;
  int failures = 0;

  rf_tx_iq_streamer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .en_in         (en_in),
    .loop_mode     (loop_mode),
    .rftxdata      (rftxdata),
    .rftxen        (rftxen),
    .rftxiqsel     (rftxiqsel),
    .underrun      (underrun),
    .level         (level)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {
    logic            valid;
    logic [2*DW-1:0] data;
    logic            en;
    logic            loop;
    logic            e_en;
    logic            e_iq;
    logic [DW-1:0]   e_raw;
    logic [AW:0]     e_lvl;
    logic            e_rdy;
    logic            e_ur;
  } vec_t;

  vec_t tbl [9];

  function automatic logic [DW-1:0] exp_fmt(input logic [DW-1:0] s);
`ifdef RFTX_OFFSET_BINARY_EN
    return {~s[DW-1], s[DW-2:0]};
`else
    return s;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic e_en, input logic e_iq,
                         input logic [DW-1:0] raw);
    chk({nm, ".rftxen"},    32'(rftxen),    32'(e_en));
    chk({nm, ".rftxiqsel"}, 32'(rftxiqsel), 32'(e_iq));
    chk({nm, ".rftxdata"},  32'(rftxdata),  32'(e_en ? exp_fmt(raw) : c_idle));
  endtask

  task automatic cyc();
    @(posedge clk_clk);
    #1;
  endtask

  logic [DW-1:0] li [3];
  logic [DW-1:0] lq [3];
  int p;

  initial begin
    tbl[0] = '{1'b1, {12'h123, 12'h456}, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 7'd1, 1'b1, 1'b0};
    tbl[1] = '{1'b1, {12'h789, 12'hABC}, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 7'd2, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 24'h0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h123, 7'd2, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 24'h0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h456, 7'd2, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 24'h0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h789, 7'd1, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 24'h0, 1'b1, 1'b0, 1'b1, 1'b0, 12'hABC, 7'd1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 24'h0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 7'd0, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 7'd0, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 24'h0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 7'd0, 1'b1, 1'b0};
    li[0] = 12'h100; li[1] = 12'h101; li[2] = 12'h102;
    lq[0] = 12'h800; lq[1] = 12'h801; lq[2] = 12'h802;

    reset_reset_n = 1'b0;
    s_data = '0; s_valid = 1'b0; en_in = 1'b0; loop_mode = 1'b0;
    #3;
    chk_out("reset", 1'b0, 1'b0, 12'h000);
    chk("reset.level",    32'(level),    32'd0);
    chk("reset.s_ready",  32'(s_ready),  32'd0);
    chk("reset.underrun", 32'(underrun), 32'd0);
    cyc(); cyc();
    reset_reset_n = 1'b1;
    chk("release.s_ready_low", 32'(s_ready), 32'd0);
    cyc();
    chk("release.s_ready_rise", 32'(s_ready), 32'd1);

    // Two-pair one-shot stream ending in underrun, then clear
    for (int i = 0; i < 9; i++) begin
      s_valid = tbl[i].valid; s_data = tbl[i].data;
      en_in = tbl[i].en; loop_mode = tbl[i].loop;
      cyc();
      chk_out($sformatf("stream[%0d]", i), tbl[i].e_en, tbl[i].e_iq, tbl[i].e_raw);
      chk($sformatf("stream[%0d].level", i),    32'(level),    32'(tbl[i].e_lvl));
      chk($sformatf("stream[%0d].s_ready", i),  32'(s_ready),  32'(tbl[i].e_rdy));
      chk($sformatf("stream[%0d].underrun", i), 32'(underrun), 32'(tbl[i].e_ur));
    end

    // Loop replay of three pairs, writes ignored while looping
    en_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1; s_data = {li[k], lq[k]};
      cyc();
    end
    s_valid = 1'b0;
    chk("loop.fill_level", 32'(level), 32'd3);
    loop_mode = 1'b1; en_in = 1'b1;
    for (int j = 0; j < 14; j++) begin
      if (j == 1) begin s_valid = 1'b1; s_data = {12'hFFF, 12'hEEE}; end
      cyc();
      p = (j / 2) % 3;
      chk_out($sformatf("loop[%0d]", j), 1'b1, (j % 2) == 0, ((j % 2) == 0) ? li[p] : lq[p]);
      chk($sformatf("loop[%0d].s_ready", j), 32'(s_ready), 32'd0);
      chk($sformatf("loop[%0d].level", j),   32'(level),   32'd3);
    end
    en_in = 1'b0; s_valid = 1'b0; loop_mode = 1'b0;
    cyc();
    chk_out("loop.exit", 1'b0, 1'b0, 12'h000);
    chk("loop.exit.level",    32'(level),    32'd3);
    chk("loop.exit.underrun", 32'(underrun), 32'd0);

    // Second run restarts at the oldest pair
    en_in = 1'b1;
    cyc(); chk_out("rerun.I", 1'b1, 1'b1, li[0]);
    cyc(); chk_out("rerun.Q", 1'b1, 1'b0, lq[0]);
    en_in = 1'b0;
    cyc(); chk_out("rerun.idle", 1'b0, 1'b0, 12'h000);
    chk("rerun.level", 32'(level), 32'd2);

    // Disable during I phase still completes the pair
    en_in = 1'b1;
    cyc(); chk_out("midpair.I", 1'b1, 1'b1, li[1]);
    en_in = 1'b0;
    cyc(); chk_out("midpair.Q", 1'b1, 1'b0, lq[1]);
    cyc(); chk_out("midpair.idle", 1'b0, 1'b0, 12'h000);
    chk("midpair.underrun", 32'(underrun), 32'd0);
    chk("midpair.level",    32'(level),    32'd1);

    en_in = 1'b1;
    cyc(); chk_out("flush.I", 1'b1, 1'b1, li[2]);
    cyc(); chk_out("flush.Q", 1'b1, 1'b0, lq[2]);
    cyc(); chk("flush.underrun", 32'(underrun), 32'd1);
    chk("flush.level", 32'(level), 32'd0);
    en_in = 1'b0;
    cyc(); chk("flush.underrun_clear", 32'(underrun), 32'd0);

    // Full buffer
    for (int k = 0; k < 64; k++) begin
      s_valid = 1'b1; s_data = {12'h300 + 12'(k), 12'hC00 + 12'(k)};
      cyc();
    end
    chk("full.level",   32'(level),   32'd64);
    chk("full.s_ready", 32'(s_ready), 32'd0);
    s_data = {12'h5A5, 12'hA5A};
    cyc();
    chk("full.ignored_level", 32'(level), 32'd64);
    en_in = 1'b1;
    cyc(); chk_out("full.A", 1'b1, 1'b1, 12'h300);
    chk("full.A.s_ready", 32'(s_ready), 32'd0); chk("full.A.level", 32'(level), 32'd64);
    cyc(); chk_out("full.B", 1'b1, 1'b0, 12'hC00);
    chk("full.B.s_ready", 32'(s_ready), 32'd0); chk("full.B.level", 32'(level), 32'd64);
    cyc(); chk_out("full.C", 1'b1, 1'b1, 12'h301);
    chk("full.C.s_ready", 32'(s_ready), 32'd1); chk("full.C.level", 32'(level), 32'd63);
    cyc(); chk_out("full.D", 1'b1, 1'b0, 12'hC01);
    chk("full.D.s_ready", 32'(s_ready), 32'd0); chk("full.D.level", 32'(level), 32'd64);
    cyc(); chk_out("full.E", 1'b1, 1'b1, 12'h302);
    chk("full.E.s_ready", 32'(s_ready), 32'd1); chk("full.E.level", 32'(level), 32'd63);
    cyc(); chk_out("full.F", 1'b1, 1'b0, 12'hC02);
    chk("full.F.level", 32'(level), 32'd64);
    cyc(); chk_out("full.G", 1'b1, 1'b1, 12'h303);
    cyc(); chk_out("full.H", 1'b1, 1'b0, 12'hC03);

    // Asynchronous reset during Q phase, no clock edge in between
    #2;
    reset_reset_n = 1'b0;
    #1;
    chk_out("areset", 1'b0, 1'b0, 12'h000);
    chk("areset.level",    32'(level),    32'd0);
    chk("areset.s_ready",  32'(s_ready),  32'd0);
    chk("areset.underrun", 32'(underrun), 32'd0);
    s_valid = 1'b0; en_in = 1'b0;
    cyc();
    chk("areset.held_s_ready", 32'(s_ready), 32'd0);
    reset_reset_n = 1'b1;
    cyc();
    chk("areset.release_s_ready", 32'(s_ready), 32'd1);
    chk_out("areset.release", 1'b0, 1'b0, 12'h000);
    chk("areset.release_level", 32'(level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
